serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Parametrised bit-serial multi-bit subtractor. It computes diff = a - b - bin over WIDTH-bit operands, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential, width-generic successor to the 1-bit full subtractor. It uses a start/busy/done handshake and flags unsigned borrow-out and signed overflow. Intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.
CNT_W, $clog2(WIDTH) (minimum 1), bit counter width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while idle
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: diff/bout/ovf updated this cycle
diff  output  WIDTH  result a - b - bin (mod 2^WIDTH)
bout  output  1  final borrow (unsigned a < b + bin)
ovf  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Clock and reset: clk and rst_n are the only clock and reset. rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy, done, diff, bout, ovf = 0.
  - Operand shift registers, result shift register, borrow FF and counter = 0.
- States: IDLE, RUN.
- IDLE:
  - start=1 at an edge (edge E0) loads a→a_sh, b→b_sh, bin→borrow FF.
  - Stores a[WIDTH-1] and b[WIDTH-1] for ovf. Sets counter=0, busy=1, state→RUN.
  - start=0: remain IDLE.
- RUN, each edge:
  - Bit cell: d = a_sh[0]^b_sh[0]^br; bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - d shifts into the MSB of the result shift register (shift right). a_sh and b_sh shift right. br←bo. Counter increments.
  - At the edge where counter==WIDTH-1 (edge E_WIDTH):
    - diff←final result; bout←bo.
    - ovf←(a_msb^b_msb)&(a_msb^d_final), where d_final is the last bit cell output.
    - done←1, busy←0, state→IDLE.
- Latency: accept at E0; busy high after E0 through E_WIDTH; done high for exactly the one cycle after E_WIDTH. Throughput is one result per WIDTH+1 cycles.
- done: deasserts on the following edge unless another completion occurs.
- Outputs diff/bout/ovf:
  - Change only at a completion edge.
  - Hold their value through the next run until the next completion.
- Operand stability: a, b and bin are ignored after capture. Changing them during RUN has no effect.
- start during RUN: ignored, with no queuing.
- start high in the cycle done=1 (state IDLE): accepted. Holding start continuously gives back-to-back operations.
- Reset mid-operation: aborts immediately. No done pulse. The next start after reset release operates normally.
- WIDTH=1: a single RUN edge. ovf = (a^b)&(a^diff) on bit 0.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package subtractor_pkg:
  - State encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1.
  - A function for the 1-bit difference/borrow equations, shared with any parallel subtractor.
- One sub-module: full_sub_cell, a combinational 1-bit cell (a, b, bin → d, bo), instantiated once in the datapath.
- FSM, counter and shift registers stay in the top module.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h3C, bin=0, single start pulse.
   -> busy for 8 cycles; done exactly one cycle, 9 edges after E0 inclusive of E0; diff=8'h1E, bout=0, ovf=0.
2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0.
   a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1.
3. a=8'h7F, b=8'hFF, bin=1 -> diff=8'h7F, bout=1, ovf=0.
4. Start 8'h10-8'h01, then pulse start with a=8'hFF, b=8'h00 mid-run and change a/b inputs during RUN.
   -> result 8'h0F only, exactly one done.
   Then hold start=1 continuously -> done pulses every 9 cycles with correct results.
5. Start 8'hAA-8'h55, drive rst_n=0 after 3 RUN edges.
   -> busy/diff/bout/ovf/done go 0 immediately (asynchronous), no done.
   After release, start 8'h03-8'h05, bin=0 -> diff=8'hFE, bout=1, ovf=0.
6. WIDTH=1 instance, exhaustive sweep of {a,b,bin}=0..7.
   -> diff/bout match the 1-bit truth table; done one cycle after each RUN edge; ovf=(a^b)&(a^diff).

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared definitions for the subtractor family: state encoding and the
// 1-bit full-subtractor equations.
package subtractor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic d;
        logic bo;
    } sub_bit_t;

    // Difference and borrow-out of a - b - bin for a single bit
    function automatic sub_bit_t full_sub(input logic a, input logic b, input logic bin);
        sub_bit_t r;
        r.d  = a ^ b ^ bin;
        r.bo = (~a & b) | (~(a ^ b) & bin);
        return r;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full-subtractor cell.
module full_sub_cell
    import subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    sub_bit_t res;

    assign res = full_sub(a, b, bin);
    assign d   = res.d;
    assign bo  = res.bo;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell with a registered borrow.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   res_next;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               a_msb;
    logic               b_msb;
    logic               d_bit;
    logic               bo_bit;
    logic               accept;
    logic               running;
    logic               last;

    full_sub_cell u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (br),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign accept  = (state_q == ST_IDLE) && start;
    assign running = (state_q == ST_RUN);
    assign last    = running && (cnt == CNT_W'(WIDTH - 1));

    // Result register shifted right with the new bit entering at the MSB;
    // written per-bit so it also elaborates cleanly for WIDTH=1
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = d_bit;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept a start while idle, return to idle after the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, serial shifting and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                br    <= bin;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (running) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_next;
                br     <= bo_bit;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    diff <= res_next;
                    bout <= bo_bit;
                    ovf  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;
    logic       ovf1;

    int unsigned vectors;
    int unsigned miscompares;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1),
        .ovf   (ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: full-precision integer arithmetic, borrow from the sign of
    // the unsigned difference, overflow from the signed result range
    task automatic model(input int w, input longint ua, input longint ub, input bit ubin,
                         output logic [63:0] ed, output logic eb, output logic eo);
        longint full;
        longint sa;
        longint sb;
        longint s;
        longint half;
        half = longint'(1) << (w - 1);
        full = ua - ub - longint'(ubin);
        ed   = 64'(full) & ((64'd1 << w) - 64'd1);
        eb   = (full < 0);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        s    = sa - sb - longint'(ubin);
        eo   = (s < -half) || (s > half - 1);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete WIDTH=8 operation with garbage on the inputs while running
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input string tag);
        logic [63:0] ed;
        logic        eb;
        logic        eo;
        model(8, longint'(ta), longint'(tb_), tbin, ed, eb, eo);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; bin = tbin;
        @(negedge clk);
        start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
        chk({tag, "_done_e0"}, 64'(done), 64'd0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            chk({tag, "_busy_run"}, 64'(busy), 64'd1);
            chk({tag, "_done_run"}, 64'(done), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_diff"}, 64'(diff), ed);
        chk({tag, "_bout"}, 64'(bout), 64'(eb));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_diff_hold"}, 64'(diff), ed);
    endtask

    initial begin
        logic [63:0] ed;
        logic        eb;
        logic        eo;
        int          ndone;
        logic [7:0]  seen;
        logic [7:0]  qa[6];
        logic [7:0]  qb[6];
        int          cyc;
        int          last_cyc;
        bit          got;

        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst1_busy", 64'(busy1), 64'd0);
        chk("rst1_diff", 64'(diff1), 64'd0);
        rst_n = 1'b1;

        // Directed cases
        run8(8'h5A, 8'h3C, 1'b0, "t1");
        run8(8'h00, 8'h01, 1'b0, "t2a");
        run8(8'h80, 8'h01, 1'b0, "t2b");
        run8(8'h7F, 8'hFF, 1'b1, "t3");

        // Random operations
        for (int i = 0; i < 16; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), "rnd");
        end

        // Start and operand changes during RUN are ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h33; b = 8'hC4;
        ndone = 0;
        seen  = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                seen = diff;
            end
        end
        chk("t4_ndone", 64'(ndone), 64'd1);
        chk("t4_diff", 64'(seen), 64'h0F);

        // Held start: back-to-back operations, one done every 9 cycles
        for (int i = 0; i < 6; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b1; a = qa[0]; b = qb[0]; bin = 1'b0;
        cyc = 0;
        last_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                cyc++;
                if (done) got = 1'b1;
            end
            chk("b2b_timeout", 64'(got), 64'd1);
            model(8, longint'(qa[i]), longint'(qb[i]), 1'b0, ed, eb, eo);
            chk("b2b_diff", 64'(diff), ed);
            chk("b2b_bout", 64'(bout), 64'(eb));
            chk("b2b_ovf", 64'(ovf), 64'(eo));
            if (i > 0) chk("b2b_period", 64'(cyc - last_cyc), 64'd9);
            last_cyc = cyc;
            if (i < 5) begin
                a = qa[i + 1];
                b = qb[i + 1];
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_diff", 64'(diff), 64'd0);
        chk("t5_bout", 64'(bout), 64'd0);
        chk("t5_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done", 64'(ndone), 64'd0);
        run8(8'h03, 8'h05, 1'b0, "t5_after");

        // WIDTH=1 exhaustive sweep
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            model(1, longint'(vv[2]), longint'(vv[1]), vv[0], ed, eb, eo);
            @(negedge clk);
            start1 = 1'b1; a1 = vv[2]; b1 = vv[1]; bin1 = vv[0];
            @(negedge clk);
            start1 = 1'b0; a1 = ~vv[2]; b1 = ~vv[1]; bin1 = ~vv[0];
            chk("w1_busy", 64'(busy1), 64'd1);
            chk("w1_done_e0", 64'(done1), 64'd0);
            @(negedge clk);
            chk("w1_done", 64'(done1), 64'd1);
            chk("w1_busy_end", 64'(busy1), 64'd0);
            chk("w1_diff", 64'(diff1), ed);
            chk("w1_bout", 64'(bout1), 64'(eb));
            chk("w1_ovf", 64'(ovf1), 64'(eo));
            @(negedge clk);
            chk("w1_done_clr", 64'(done1), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
